// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lsu_pkg
//  Purpose  : Shared encodings and helpers for the load/store unit:
//             access-type codes, FSM state enum, byte-enable, access-size
//             and alignment helpers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

  // Access type codes carried on i_bhw_type
  localparam logic [2:0] BHW_W  = 3'b001;
  localparam logic [2:0] BHW_H  = 3'b010;
  localparam logic [2:0] BHW_D  = 3'b011;
  localparam logic [2:0] BHW_B  = 3'b100;
  localparam logic [2:0] BHW_WU = 3'b101;
  localparam logic [2:0] BHW_BU = 3'b110;
  localparam logic [2:0] BHW_HU = 3'b111;

  // FSM state encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } lsu_state_e;

  // Unshifted lane mask for an access type (undefined codes select nothing)
  function automatic logic [7:0] lsu_size_mask(input logic [2:0] bhw);
    logic [7:0] m;
    case (bhw)
      BHW_B, BHW_BU: m = 8'h01;
      BHW_H, BHW_HU: m = 8'h03;
      BHW_W, BHW_WU: m = 8'h0F;
      BHW_D:         m = 8'hFF;
      default:       m = 8'h00;
    endcase
    return m;
  endfunction

  // Byte enables for an access placed at byte offset 'off' within the word
  function automatic logic [7:0] lsu_byte_en(input logic [2:0] bhw,
                                             input logic [2:0] off);
    return lsu_size_mask(bhw) << off;
  endfunction

  // Alignment check; doubleword only exists on a 64-bit datapath
  function automatic logic lsu_misaligned(input logic [2:0] bhw,
                                          input logic [2:0] off,
                                          input logic       is64);
    logic mis;
    case (bhw)
      BHW_B, BHW_BU: mis = 1'b0;
      BHW_H, BHW_HU: mis = off[0];
      BHW_W, BHW_WU: mis = |off[1:0];
      BHW_D:         mis = !is64 || (|off);
      default:       mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lsu_load_align
//  Purpose  : Combinational load lane extraction and sign/zero extension.
//  Ports    : i_rdata  - raw memory word
//             i_off    - byte offset of the access inside the word
//             i_bhw    - access type code
//             o_data   - extracted, extended load result
//  Revision : 1.0 - initial release
// ============================================================================
module mem_lsu_load_align
  import mem_lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [2:0]        i_bhw,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_word_s;
  logic [DATA_W-1:0] w_word_u;

  // Addressed lane moved down to bit 0
  assign w_shift = i_rdata >> {i_off, 3'b000};

  // A word access only needs extending when the datapath is wider than 32
  generate
    if (DATA_W > 32) begin : g_wide
      assign w_word_s = {{(DATA_W-32){w_shift[31]}}, w_shift[31:0]};
      assign w_word_u = {{(DATA_W-32){1'b0}},        w_shift[31:0]};
    end else begin : g_narrow
      assign w_word_s = w_shift;
      assign w_word_u = w_shift;
    end
  endgenerate

  always_comb begin
    o_data = w_shift;
    case (i_bhw)
      BHW_B:  o_data = {{(DATA_W-8){w_shift[7]}},   w_shift[7:0]};
      BHW_BU: o_data = {{(DATA_W-8){1'b0}},         w_shift[7:0]};
      BHW_H:  o_data = {{(DATA_W-16){w_shift[15]}}, w_shift[15:0]};
      BHW_HU: o_data = {{(DATA_W-16){1'b0}},        w_shift[15:0]};
      BHW_W:  o_data = w_word_s;
      BHW_WU: o_data = w_word_u;
      default: o_data = w_shift;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lsu
//  Purpose  : Pipeline memory stage. Issues one load/store at a time on a
//             req/ack memory port, stalls upstream while waiting, checks
//             alignment, times out a silent memory and retires every op into
//             a one-cycle writeback pulse.
//  Ports    : i_clk/i_reset          - clock, synchronous active-high reset
//             i_valid..i_bhw_type    - op from the previous pipeline stage
//             o_mem_* / i_mem_*      - memory request/response port
//             o_stall                - hold upstream inputs
//             o_m_rd                 - forwarding copy of i_rd
//             o_wb_*                 - registered writeback outputs
//             o_misalign/o_bus_err   - one-cycle error pulses
//  Revision : 1.0 - initial release
// ============================================================================
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  // pipeline side
  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [4:0]            i_rd,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic                  i_mem_to_reg,
  input  logic                  i_reg_write,
  input  logic [2:0]            i_bhw_type,
  // memory port
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W/8-1:0]   o_mem_be,
  output logic [DATA_W-1:0]     o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  // control / writeback
  output logic                  o_stall,
  output logic [4:0]            o_m_rd,
  output logic                  o_wb_valid,
  output logic [DATA_W-1:0]     o_wb_read_data,
  output logic [ADDR_W-1:0]     o_wb_alu_result,
  output logic [4:0]            o_wb_rd,
  output logic                  o_wb_mem_to_reg,
  output logic                  o_wb_reg_write,
  output logic                  o_misalign,
  output logic                  o_bus_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  // ---------------------------------------------------------------- decode
  logic              w_mem_op;
  logic [OFF_W-1:0]  w_off;
  logic [2:0]        w_off3;
  logic              w_misalign;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_lane_mask;
  logic [DATA_W-1:0] w_store_data;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_timeout;
  logic [DATA_W-1:0] w_load_data;

  assign w_mem_op   = i_valid & (i_mem_read | i_mem_write);
  assign w_off      = i_addr[OFF_W-1:0];
  assign w_off3     = 3'(w_off);
  assign w_misalign = lsu_misaligned(i_bhw_type, w_off3, (DATA_W == 64));
  assign w_be       = NB'(lsu_byte_en(i_bhw_type, w_off3));
  assign w_mem_addr = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Expand byte enables to a bit mask so unselected lanes read as zero
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign w_lane_mask[8*gi +: 8] = {8{w_be[gi]}};
    end
  endgenerate

  assign w_store_data = (i_wdata << {w_off, 3'b000}) & w_lane_mask;

  // ---------------------------------------------------------------- state
  lsu_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [NB-1:0]     be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_bhw_q, op_bhw_d;
  logic [OFF_W-1:0]  op_off_q, op_off_d;
  logic [4:0]        op_rd_q, op_rd_d;
  logic [ADDR_W-1:0] op_alu_q, op_alu_d;
  logic              op_m2r_q, op_m2r_d;
  logic              op_rw_q, op_rw_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
  logic [ADDR_W-1:0] wb_alu_q, wb_alu_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_m2r_q, wb_m2r_d;
  logic              wb_rw_q, wb_rw_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;

  // Last permitted BUSY cycle; ack in this same cycle still wins
  assign w_timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  mem_lsu_load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .i_rdata (i_mem_rdata),
    .i_off   (op_off_q),
    .i_bhw   (op_bhw_q),
    .o_data  (w_load_data)
  );

  // The timeout cycle retires the op, so the stall must drop there too;
  // otherwise upstream would replay the same faulting access forever.
  always_comb begin
    o_stall = 1'b0;
    if (state_q == ST_IDLE)
      o_stall = w_mem_op & ~w_misalign;
    else
      o_stall = ~i_mem_ack & ~w_timeout;
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    maddr_d    = maddr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    op_bhw_d   = op_bhw_q;
    op_off_d   = op_off_q;
    op_rd_d    = op_rd_q;
    op_alu_d   = op_alu_q;
    op_m2r_d   = op_m2r_q;
    op_rw_d    = op_rw_q;
    wb_valid_d = 1'b0;
    wb_rdata_d = wb_rdata_q;
    wb_alu_d   = wb_alu_q;
    wb_rd_d    = wb_rd_q;
    wb_m2r_d   = wb_m2r_q;
    wb_rw_d    = wb_rw_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (w_mem_op && !w_misalign) begin
            state_d  = ST_BUSY;
            req_d    = 1'b1;
            we_d     = ~i_mem_read;   // read wins when both are set
            maddr_d  = w_mem_addr;
            be_d     = w_be;
            wdata_d  = i_mem_read ? '0 : w_store_data;
            cnt_d    = '0;
            op_bhw_d = i_bhw_type;
            op_off_d = w_off;
            op_rd_d  = i_rd;
            op_alu_d = i_addr;
            op_m2r_d = i_mem_to_reg;
            op_rw_d  = i_reg_write;
          end else begin
            // Non-memory op or misaligned access: retire immediately
            wb_valid_d = 1'b1;
            wb_alu_d   = i_addr;
            wb_rd_d    = i_rd;
            wb_m2r_d   = i_mem_to_reg;
            wb_rw_d    = w_mem_op ? 1'b0 : i_reg_write;
            misalign_d = w_mem_op;
          end
        end
      end
      ST_BUSY: begin
        if (i_mem_ack || w_timeout) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_alu_d   = op_alu_q;
          wb_rd_d    = op_rd_q;
          wb_m2r_d   = op_m2r_q;
          if (i_mem_ack) begin
            wb_rw_d = op_rw_q;
            if (!we_q)
              wb_rdata_d = w_load_data;
          end else begin
            wb_rw_d   = 1'b0;
            bus_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      op_bhw_q   <= '0;
      op_off_q   <= '0;
      op_rd_q    <= '0;
      op_alu_q   <= '0;
      op_m2r_q   <= 1'b0;
      op_rw_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rdata_q <= '0;
      wb_alu_q   <= '0;
      wb_rd_q    <= '0;
      wb_m2r_q   <= 1'b0;
      wb_rw_q    <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      maddr_q    <= maddr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      op_bhw_q   <= op_bhw_d;
      op_off_q   <= op_off_d;
      op_rd_q    <= op_rd_d;
      op_alu_q   <= op_alu_d;
      op_m2r_q   <= op_m2r_d;
      op_rw_q    <= op_rw_d;
      wb_valid_q <= wb_valid_d;
      wb_rdata_q <= wb_rdata_d;
      wb_alu_q   <= wb_alu_d;
      wb_rd_q    <= wb_rd_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rw_q    <= wb_rw_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign o_mem_req       = req_q;
  assign o_mem_we        = we_q;
  assign o_mem_addr      = maddr_q;
  assign o_mem_be        = be_q;
  assign o_mem_wdata     = wdata_q;
  assign o_m_rd          = i_rd;
  assign o_wb_valid      = wb_valid_q;
  assign o_wb_read_data  = wb_rdata_q;
  assign o_wb_alu_result = wb_alu_q;
  assign o_wb_rd         = wb_rd_q;
  assign o_wb_mem_to_reg = wb_m2r_q;
  assign o_wb_reg_write  = wb_rw_q;
  assign o_misalign      = misalign_q;
  assign o_bus_err       = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_lsu
//  Purpose  : Self-checking bench for mem_lsu. A 32-bit instance and a 64-bit
//             instance share one stimulus bus; sel64 picks which one is live.
//             Expected values come from an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

  localparam int TO32 = 4;
  localparam int TO64 = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel64;
  logic        valid, mem_read, mem_write, m2r_in, rw_in, ack;
  logic [31:0] addr;
  logic [63:0] wdata, rdata;
  logic [4:0]  rd_in;
  logic [2:0]  bhw;

  always #5 clk = ~clk;

  // 32-bit instance outputs
  logic        req32, we32, stall32, wbv32, wbm2r32, wbrw32, mis32, berr32;
  logic [31:0] maddr32, mwdata32, wbrd32, wbalu32;
  logic [3:0]  be32;
  logic [4:0]  mrd32, wbrdx32;
  // 64-bit instance outputs
  logic        req64, we64, stall64, wbv64, wbm2r64, wbrw64, mis64, berr64;
  logic [31:0] maddr64, wbalu64;
  logic [63:0] mwdata64, wbrd64;
  logic [7:0]  be64;
  logic [4:0]  mrd64, wbrdx64;

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(TO32)) dut32 (
    .i_clk(clk), .i_reset(rst), .i_valid(valid & ~sel64), .i_addr(addr),
    .i_wdata(wdata[31:0]), .i_rd(rd_in), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_mem_to_reg(m2r_in), .i_reg_write(rw_in),
    .i_bhw_type(bhw), .o_mem_req(req32), .o_mem_we(we32),
    .o_mem_addr(maddr32), .o_mem_be(be32), .o_mem_wdata(mwdata32),
    .i_mem_ack(ack & ~sel64), .i_mem_rdata(rdata[31:0]), .o_stall(stall32),
    .o_m_rd(mrd32), .o_wb_valid(wbv32), .o_wb_read_data(wbrd32),
    .o_wb_alu_result(wbalu32), .o_wb_rd(wbrdx32), .o_wb_mem_to_reg(wbm2r32),
    .o_wb_reg_write(wbrw32), .o_misalign(mis32), .o_bus_err(berr32));

  mem_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(TO64)) dut64 (
    .i_clk(clk), .i_reset(rst), .i_valid(valid & sel64), .i_addr(addr),
    .i_wdata(wdata), .i_rd(rd_in), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_mem_to_reg(m2r_in), .i_reg_write(rw_in),
    .i_bhw_type(bhw), .o_mem_req(req64), .o_mem_we(we64),
    .o_mem_addr(maddr64), .o_mem_be(be64), .o_mem_wdata(mwdata64),
    .i_mem_ack(ack & sel64), .i_mem_rdata(rdata), .o_stall(stall64),
    .o_m_rd(mrd64), .o_wb_valid(wbv64), .o_wb_read_data(wbrd64),
    .o_wb_alu_result(wbalu64), .o_wb_rd(wbrdx64), .o_wb_mem_to_reg(wbm2r64),
    .o_wb_reg_write(wbrw64), .o_misalign(mis64), .o_bus_err(berr64));

  // Live-instance view
  logic        req, we, stall, wbv, wbm2r, wbrw, mis, berr;
  logic [31:0] maddr, wbalu;
  logic [63:0] mwdata, wbrd;
  logic [7:0]  be;
  logic [4:0]  mrd, wbrdx;
  assign req    = sel64 ? req64    : req32;
  assign we     = sel64 ? we64     : we32;
  assign stall  = sel64 ? stall64  : stall32;
  assign wbv    = sel64 ? wbv64    : wbv32;
  assign wbm2r  = sel64 ? wbm2r64  : wbm2r32;
  assign wbrw   = sel64 ? wbrw64   : wbrw32;
  assign mis    = sel64 ? mis64    : mis32;
  assign berr   = sel64 ? berr64   : berr32;
  assign maddr  = sel64 ? maddr64  : maddr32;
  assign wbalu  = sel64 ? wbalu64  : wbalu32;
  assign mwdata = sel64 ? mwdata64 : {32'b0, mwdata32};
  assign wbrd   = sel64 ? wbrd64   : {32'b0, wbrd32};
  assign be     = sel64 ? be64     : {4'b0, be32};
  assign mrd    = sel64 ? mrd64    : mrd32;
  assign wbrdx  = sel64 ? wbrdx64  : wbrdx32;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- reference model
  function automatic int ref_size(input logic [2:0] t, input bit w64);
    case (t)
      3'b100, 3'b110: return 1;
      3'b010, 3'b111: return 2;
      3'b001, 3'b101: return 4;
      3'b011:         return w64 ? 8 : 0;
      default:        return 0;
    endcase
  endfunction

  function automatic bit ref_signed(input logic [2:0] t);
    return (t == 3'b100) || (t == 3'b010) || (t == 3'b001);
  endfunction

  function automatic bit ref_misalign(input logic [2:0] t, input logic [31:0] a,
                                      input bit w64);
    int sz = ref_size(t, w64);
    return (sz == 0) || ((a % sz) != 0);
  endfunction

  function automatic logic [63:0] ref_mask(input int sz);
    return (sz >= 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [63:0] d, input bit w64);
    int sz = ref_size(t, w64);
    int nb = w64 ? 8 : 4;
    logic [63:0] v, m;
    m = ref_mask(sz);
    v = (d >> (8 * (a % nb))) & m;
    if (ref_signed(t) && v[8*sz-1]) v = v | ~m;
    if (!w64) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // ---------------------------------------------------------- op driver
  logic [63:0] last_rdata, last_wdata;
  logic [31:0] last_maddr;
  logic [7:0]  last_be;
  int          last_stalls;

  // ack_after: BUSY cycles without ack before the ack cycle; -1 = never ack
  task automatic do_op(input bit rd_op, input bit wr_op, input logic [2:0] t,
                       input logic [31:0] a, input logic [63:0] wd,
                       input logic [63:0] rdv, input int ack_after);
    int nb, to, k, stalls, sz;
    bit is_mem, is_mis, to_exp, done;
    logic [4:0] rdn;
    bit rwn, m2rn;
    logic [63:0] rdm;
    nb = sel64 ? 8 : 4;
    to = sel64 ? TO64 : TO32;
    is_mem = rd_op | wr_op;
    is_mis = is_mem && ref_misalign(t, a, sel64);
    to_exp = is_mem && !is_mis && (ack_after < 0 || ack_after >= to);
    sz     = ref_size(t, sel64);
    rdm    = sel64 ? rdv : (rdv & 64'hFFFF_FFFF);
    rdn    = 5'($urandom);
    rwn    = 1'($urandom);
    m2rn   = 1'($urandom);
    stalls = 0;
    done   = 0;

    @(negedge clk);
    valid = 1; mem_read = rd_op; mem_write = wr_op; bhw = t; addr = a;
    wdata = wd; rd_in = rdn; rw_in = rwn; m2r_in = m2rn; ack = 0;
    #1;
    check_eq("m_rd", mrd, rdn);
    check_eq("req_idle", req, 0);
    if (is_mem && !is_mis) begin
      check_eq("stall_idle", stall, 1);
      stalls++;
      k = 0;
      while (!done && k < to + 2) begin
        @(negedge clk);
        k++;
        check_eq("mem_req", req, 1);
        check_eq("mem_we", we, !rd_op);
        check_eq("mem_addr", maddr, a - (a % nb));
        check_eq("mem_be", be, ((64'd1 << sz) - 64'd1) << (a % nb));
        if (!rd_op)
          check_eq("mem_wdata", mwdata,
                   ((wd & ref_mask(sz)) << (8 * (a % nb))) & ref_mask(nb));
        last_be = be; last_wdata = mwdata; last_maddr = maddr;
        if (k == ack_after + 1) begin
          ack = 1; rdata = rdv;
          #1;
          check_eq("stall_ack", stall, 0);
          done = 1;
        end else begin
          #1;
          if (k == to) begin
            check_eq("stall_tmo", stall, 0);
            done = 1;
          end else begin
            check_eq("stall_busy", stall, 1);
            stalls++;
          end
        end
      end
      check_eq("busy_bound", done, 1);
    end else begin
      check_eq("stall_nomem", stall, 0);
    end

    @(negedge clk);
    check_eq("wb_valid", wbv, 1);
    check_eq("wb_rd", wbrdx, rdn);
    check_eq("wb_alu", wbalu, a);
    check_eq("wb_m2r", wbm2r, m2rn);
    check_eq("wb_rw", wbrw, (is_mis || to_exp) ? 0 : rwn);
    check_eq("misalign", mis, is_mis);
    check_eq("bus_err", berr, to_exp);
    check_eq("req_after", req, 0);
    if (rd_op && !is_mis && !to_exp)
      check_eq("wb_rdata", wbrd, ref_load(t, a, rdm, sel64));
    last_rdata  = wbrd;
    last_stalls = stalls;
    valid = 0; mem_read = 0; mem_write = 0; ack = 0;

    @(negedge clk);
    check_eq("wb_pulse", wbv, 0);
    check_eq("wb_hold_rd", wbrdx, rdn);
    check_eq("err_pulse", mis | berr, 0);
  endtask

  task automatic reset_check();
    @(negedge clk);
    rst = 1; valid = 0; ack = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel64 = s[0];
      #1;
      check_eq("rst_wbv", wbv, 0);
      check_eq("rst_req", req, 0);
      check_eq("rst_rdata", wbrd, 0);
      check_eq("rst_rd", wbrdx, 0);
      check_eq("rst_err", {mis, berr, wbrw, wbm2r}, 0);
    end
    rst = 0;
    sel64 = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, ad;
    logic [31:0] ra;
    rst = 1; sel64 = 0; valid = 0; mem_read = 0; mem_write = 0; ack = 0;
    addr = 0; wdata = 0; rdata = 0; rd_in = 0; bhw = 0; m2r_in = 0; rw_in = 0;
    reset_check();

    // ---- 32-bit directed
    sel64 = 0;
    do_op(0, 1, 3'b100, 32'h3, 64'hAB, 0, 0);                 // SB
    check_eq("sb_be", last_be, 8'b1000);
    check_eq("sb_wdata", last_wdata, 64'hAB00_0000);
    check_eq("sb_addr", last_maddr, 0);
    do_op(1, 0, 3'b100, 32'h1, 0, 64'h8000, 3);               // LB
    check_eq("lb_stalls", last_stalls, 4);
    check_eq("lb_data", last_rdata, 64'hFFFF_FF80);
    do_op(1, 0, 3'b110, 32'h1, 0, 64'h8000, 3);               // LBU
    check_eq("lbu_data", last_rdata, 64'h0000_0080);
    do_op(1, 0, 3'b001, 32'h2, 0, 0, 0);                      // LW misaligned
    do_op(1, 0, 3'b001, 32'h0, 0, 64'h1234, -1);              // LW timeout
    check_eq("tmo_stalls", last_stalls, 4);
    do_op(1, 0, 3'b001, 32'h4, 0, 64'hCAFE_F00D, 0);          // accepted after
    check_eq("post_tmo", last_rdata, 64'hCAFE_F00D);
    do_op(1, 0, 3'b010, 32'h6, 0, 64'h8001_0000, 3);          // ack in last cycle
    check_eq("ack_wins", last_rdata, 64'hFFFF_8001);
    do_op(1, 0, 3'b011, 32'h0, 0, 0, 0);                      // LD on 32: misaligned
    do_op(0, 0, 3'b000, 32'h55, 0, 0, 0);                     // non-memory

    // ---- reset in 2nd BUSY cycle
    @(negedge clk);
    valid = 1; mem_read = 1; bhw = 3'b001; addr = 32'h8;
    @(negedge clk);
    #1 check_eq("rb_req1", req, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_eq("rb_req", req, 0);
    check_eq("rb_wbv", wbv, 0);
    check_eq("rb_err", berr, 0);
    rst = 0; valid = 0; mem_read = 0;
    do_op(1, 0, 3'b001, 32'h8, 0, 64'h0BAD_BEEF, 1);

    // ---- 64-bit directed
    sel64 = 1;
    do_op(1, 0, 3'b011, 32'h8, 0, 64'h8000_0000_0000_0001, 2); // LD
    check_eq("ld_data", last_rdata, 64'h8000_0000_0000_0001);
    do_op(0, 1, 3'b010, 32'h6, 64'h1234, 0, 0);                 // SH
    check_eq("sh_be", last_be, 8'hC0);
    do_op(1, 0, 3'b001, 32'h4, 0, 64'h8765_4321_0000_0000, 0);  // LW upper
    check_eq("lw64", last_rdata, 64'hFFFF_FFFF_8765_4321);
    do_op(1, 1, 3'b101, 32'h4, 0, 64'h8765_4321_0000_0000, 1);  // read priority
    check_eq("lwu64", last_rdata, 64'h0000_0000_8765_4321);

    // ---- randomized
    for (int i = 0; i < 120; i++) begin
      sel64 = 1'($urandom);
      kind  = $urandom_range(0, 3);
      ra    = $urandom;
      if ($urandom_range(0, 2) != 0) ra = ra & ~32'h1;
      if ($urandom_range(0, 1) != 0) ra = ra & ~32'h7;
      ad = $urandom_range(0, sel64 ? TO64 : TO32);
      if (ad == (sel64 ? TO64 : TO32)) ad = -1;
      do_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 3'($urandom), ra,
            {$urandom, $urandom}, {$urandom, $urandom}, ad);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter DATA_W, 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, 32, byte-address width.
REQ-003 SHALL have parameter TIMEOUT_CYC, 16, maximum wait for i_mem_ack; minimum 1.
REQ-004 SHALL use one clock and a synchronous, active-high reset: i_clk  in  1  clock (rising edge); i_reset  in  1  synchronous active-high reset.
REQ-005 SHALL have pipeline inputs i_valid 1, i_addr ADDR_W, i_wdata DATA_W, i_rd 5, i_mem_read 1, i_mem_write 1, i_mem_to_reg 1, i_reg_write 1, and i_bhw_type 3 (001 W, 010 H, 100 B, 101 WU, 111 HU, 110 BU, 011 D).
REQ-006 SHALL have memory-port outputs o_mem_req 1, o_mem_we 1, o_mem_addr ADDR_W, o_mem_be DATA_W/8, o_mem_wdata DATA_W, and inputs i_mem_ack 1, i_mem_rdata DATA_W.
REQ-007 SHALL have outputs o_stall 1, o_m_rd 5 (combinational copy of i_rd, for forwarding), o_wb_valid 1, o_wb_read_data DATA_W, o_wb_alu_result ADDR_W, o_wb_rd 5, o_wb_mem_to_reg 1, o_wb_reg_write 1, o_misalign 1, o_bus_err 1.

Function
REQ-008 SHALL implement FSM IDLE/BUSY; a memory op is i_valid and (i_mem_read or i_mem_write); read has priority if both are set.
REQ-009 SHALL register a valid non-memory op into the WB outputs at the next edge; latency 1, o_stall 0.
REQ-010 SHALL, in IDLE on an aligned memory op, drive o_stall=1 combinationally, register the request, and enter BUSY.
REQ-011 SHALL, in BUSY, hold o_mem_req=1 with stable address, byte enables and data until i_mem_ack.
REQ-012 SHALL drive o_mem_addr word-aligned (low log2(DATA_W/8) bits zero).
REQ-013 SHALL drive o_mem_be for the addressed lanes only: B 1 lane, H 2, W 4, D all.
REQ-014 SHALL place store data in the selected lanes, shifted by the address offset, with unselected lanes zero.
REQ-015 SHALL drive o_stall=1 in BUSY while i_mem_ack=0, and 0 in the ack cycle; the upstream stage holds its inputs while o_stall=1.
REQ-016 SHALL, on i_mem_ack, extract the addressed lane of i_mem_rdata, sign-extend for B/H/W or zero-extend for BU/HU/WU, register the result to o_wb_read_data, and return to IDLE; memory-op latency is 2 cycles plus the ack wait.
REQ-017 SHALL treat the op as misaligned when H has addr[0]!=0, W has addr[1:0]!=0, or D has addr[2:0]!=0; D when DATA_W=32 and any undefined code are also misaligned.
REQ-018 SHALL, on a misaligned op, issue no request, pulse o_misalign for 1 cycle with o_wb_valid=1, and force o_wb_reg_write=0.
REQ-019 SHALL count BUSY cycles; when the count reaches TIMEOUT_CYC without ack, it SHALL drop o_mem_req, pulse o_bus_err with o_wb_valid=1 and o_wb_reg_write=0, and return to IDLE.
REQ-020 SHALL let ack win over timeout when both occur in the same cycle.
REQ-021 SHALL assert o_wb_valid for exactly one cycle per retired op; all other WB outputs hold between ops.
REQ-022 SHALL pass o_wb_alu_result, o_wb_rd and o_wb_mem_to_reg through from the retiring op unchanged.

Reset
REQ-023 SHALL, on i_reset, clear all registered outputs to 0, the FSM to IDLE, and the timeout counter to 0 at the next edge.
REQ-024 SHALL, on reset during BUSY, drop o_mem_req at the next edge with no WB retirement and no error pulse.

Structure
REQ-025 SHALL place the bhw_type encodings, the FSM state enum and the byte-enable/lane-offset helper functions in package mem_lsu_pkg.
REQ-026 SHALL implement load lane-extraction and extension in sub-module mem_lsu_load_align, which is combinational and parametrised by DATA_W.

Verification
REQ-027 SHALL cover: DATA_W=32, SB addr 0x0000_0003, wdata 0xAB -> o_mem_be=1000, o_mem_wdata=0xAB00_0000, o_mem_addr=0x0000_0000.
REQ-028 SHALL cover: LB addr 0x1, rdata 0x0000_8000 with ack after 3 cycles -> o_stall high 4 cycles, o_wb_read_data=0xFFFF_FF80; the same case as LBU -> 0x0000_0080.
REQ-029 SHALL cover: LW addr 0x2 -> no o_mem_req, o_misalign one pulse, o_wb_reg_write=0.
REQ-030 SHALL cover: TIMEOUT_CYC=4, no ack -> o_bus_err after 4 BUSY cycles, FSM back in IDLE, next op accepted; ack in cycle 4 -> normal retire, no o_bus_err.
REQ-031 SHALL cover: DATA_W=64, LD addr 0x8, rdata 0x8000_0000_0000_0001 -> o_wb_read_data equals rdata; SH addr 0x6 -> o_mem_be=0xC0.
REQ-032 SHALL cover: i_reset asserted in the 2nd BUSY cycle -> o_mem_req=0 and o_wb_valid=0 at the next edge.
